mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, operation request from execute stage, sampled on the clk edge.
REQ-004 SHALL have port op, input, 3, with encoding 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-005 SHALL have port A, input, 32, first operand from the same forwarded operand path as the ALU (rs); source value for MTHI/MTLO.
REQ-006 SHALL have port B, input, 32, second operand (rt).
REQ-007 SHALL have port busy, output, 1, meaning an iterative operation is in progress; the pipeline holds any MFHI/MFLO or new MDU op while it is high.
REQ-008 SHALL have port hi, output, 32, architectural HI register, registered.
REQ-009 SHALL have port lo, output, 32, architectural LO register, registered.

Function
REQ-010 SHALL implement FSM states IDLE, MUL and DIV, with busy = (state != IDLE), driven from a register.
REQ-011 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored with no state, HI or LO change.
REQ-012 SHALL, on an accepted MULT/MULTU, latch the operands and go to MUL; on DIV/DIVU, latch them and go to DIV, with a 5-bit iteration counter cleared to 0.
REQ-013 SHALL, in MUL/DIV, perform one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle; the counter increments each cycle, and at count 31 the FSM returns to IDLE.
REQ-014 SHALL hold busy high for exactly 32 cycles following the accepting edge; HI/LO SHALL take the final result on the same edge at which busy falls.
REQ-015 SHALL compute signed ops (MULT, DIV) on operand magnitudes, with the sign fixed up in the final step; unsigned ops SHALL use raw operands.
REQ-016 SHALL produce a 64-bit product for MULT/MULTU, with HI = product[63:32] and LO = product[31:0].
REQ-017 SHALL produce for DIV/DIVU LO = quotient and HI = remainder; signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend A.
REQ-018 SHALL handle divide by zero (B = 0) by running the full 32 cycles and then setting LO = 32'hFFFFFFFF and HI = A.
REQ-019 SHALL handle signed overflow DIV (A = 32'h80000000, B = 32'hFFFFFFFF) by setting LO = 32'h80000000 and HI = 0.
REQ-020 SHALL, on an accepted MTHI, set HI = A, and on an accepted MTLO, set LO = A, on the accepting edge; busy SHALL stay 0 and the other register SHALL stay unchanged.
REQ-021 SHALL treat an accepted op 110/111 as a no-op that leaves busy, HI and LO unchanged.
REQ-022 SHALL leave HI/LO unchanged during MUL/DIV until the final edge, so hi and lo always show the last completed result.
REQ-023 SHALL ignore changes on A, B and op after acceptance.

Reset
REQ-024 SHALL, when rst=1 at a clk edge, force state to IDLE, busy to 0, hi and lo to 32'h0, and the counter to 0.
REQ-025 SHALL make rst take priority over start and abort any in-progress operation without writing its result.
REQ-026 SHALL, if start=1 in the first cycle after rst deasserts, accept it normally.

Configuration
REQ-027 SHALL be built with the divider when macro MDU_DIV_EN is defined, giving full DIV/DIVU behaviour per REQ-012..REQ-019.
REQ-028 SHALL, when MDU_DIV_EN is undefined, contain no divider logic; DIV/DIVU SHALL be accepted as no-ops (busy stays 0, HI/LO unchanged), and all MULT/MTHI/MTLO behaviour SHALL be identical.

Verification
REQ-029 SHALL cover MULTU with A=32'hFFFFFFFF, B=32'h2, expecting busy high for exactly 32 cycles, then HI=32'h1, LO=32'hFFFFFFFE.
REQ-030 SHALL cover MULT with A=-3, B=7, expecting HI=32'hFFFFFFFF and LO=32'hFFFFFFEB (-21).
REQ-031 SHALL cover DIV with A=-7, B=2, expecting LO=32'hFFFFFFFD (-3) and HI=32'hFFFFFFFF (-1); and DIVU with A=7, B=0, expecting LO=32'hFFFFFFFF and HI=32'h7 (MDU_DIV_EN defined).
REQ-032 SHALL cover MTHI with A=32'h1234, then a second start with a MULT during busy, expecting HI=32'h1234 in the next cycle and the second start ignored with the first result intact.
REQ-033 SHALL cover rst asserted at cycle 10 of a MULT, expecting busy=0, hi=lo=0, and no late result write.
REQ-034 SHALL cover a build with MDU_DIV_EN undefined and DIV A=9, B=3 issued, expecting busy to stay 0 and HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Purpose: 32-cycle shift-add multiplier and restoring divider feeding the
// architectural HI/LO pair, plus direct MTHI/MTLO writes.
// Build option: define MDU_DIV_EN to include the divider; without it DIV/DIVU
// are accepted as no-ops and no divider logic is built.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   start      - operation request, only accepted while idle
//   op[2:0]    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                110/111 no-op
//   A[31:0]    - first operand (rs), source for MTHI/MTLO
//   B[31:0]    - second operand (rt)
//   busy       - iterative operation in progress (registered)
//   hi, lo     - architectural HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [4:0]  cnt;
  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient}
  // for DIV; d holds the multiplicand or divisor magnitude.
  logic [63:0] p;
  logic [31:0] d;
  logic        neg_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_prod;

`ifdef MDU_DIV_EN
  logic        neg_r;
  logic        dz;
  logic [31:0] a_raw;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  logic [31:0] div_q;
  logic [31:0] div_r;
`endif

  // Signed ops (op[0] == 0) work on magnitudes; the sign is restored at the end.
  always_comb begin
    a_mag = (!op[0] && A[31]) ? (32'd0 - A) : A;
    b_mag = (!op[0] && B[31]) ? (32'd0 - B) : B;
  end

  // One shift-add step: add multiplicand to upper half when the current
  // multiplier bit is set, then shift the whole register right.
  always_comb begin
    mul_sum  = {1'b0, p[63:32]} + {1'b0, d};
    mul_next = p[0] ? {mul_sum, p[31:1]} : {1'b0, p[63:32], p[31:1]};
    mul_prod = neg_q ? (64'd0 - mul_next) : mul_next;
  end

`ifdef MDU_DIV_EN
  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only if it did not go negative.
  always_comb begin
    div_trial = {p[63:32], p[31]} - {1'b0, d};
    div_next  = div_trial[32] ? {p[62:0], 1'b0} : {div_trial[31:0], p[30:0], 1'b1};
    if (dz) begin
      div_q = 32'hFFFF_FFFF;
      div_r = a_raw;
    end else begin
      div_q = neg_q ? (32'd0 - div_next[31:0])  : div_next[31:0];
      div_r = neg_r ? (32'd0 - div_next[63:32]) : div_next[63:32];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= 32'h0;
      lo    <= 32'h0;
      cnt   <= 5'd0;
      p     <= 64'd0;
      d     <= 32'd0;
      neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      neg_r <= 1'b0;
      dz    <= 1'b0;
      a_raw <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                p     <= {32'd0, b_mag};
                d     <= a_mag;
                neg_q <= !op[0] && (A[31] ^ B[31]);
                cnt   <= 5'd0;
                state <= MUL;
                busy  <= 1'b1;
              end
`ifdef MDU_DIV_EN
              3'b010, 3'b011: begin
                p     <= {32'd0, a_mag};
                d     <= b_mag;
                neg_q <= !op[0] && (A[31] ^ B[31]);
                neg_r <= !op[0] && A[31];
                dz    <= (B == 32'd0);
                a_raw <= A;
                cnt   <= 5'd0;
                state <= DIV;
                busy  <= 1'b1;
              end
`endif
              3'b100: hi <= A;
              3'b101: lo <= A;
              default: ;
            endcase
          end
        end
        MUL: begin
          cnt <= cnt + 5'd1;
          p   <= mul_next;
          if (cnt == 5'd31) begin
            hi    <= mul_prod[63:32];
            lo    <= mul_prod[31:0];
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`ifdef MDU_DIV_EN
        DIV: begin
          cnt <= cnt + 5'd1;
          p   <= div_next;
          if (cnt == 5'd31) begin
            hi    <= div_r;
            lo    <= div_q;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  int          exp_cyc;

  mult_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Architectural reference: what HI/LO and the busy length become after an op.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    longint      x;
    longint      y;
    longint      q;
    longint      r;
    exp_cyc = 0;
    case (o)
      3'b000: begin
        prod = longint'($signed(a)) * longint'($signed(b));
        exp_hi = prod[63:32]; exp_lo = prod[31:0]; exp_cyc = 32;
      end
      3'b001: begin
        prod = {32'd0, a} * {32'd0, b};
        exp_hi = prod[63:32]; exp_lo = prod[31:0]; exp_cyc = 32;
      end
`ifdef MDU_DIV_EN
      3'b010, 3'b011: begin
        exp_cyc = 32;
        if (b == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF; exp_hi = a;
        end else begin
          if (o == 3'b010) begin
            x = longint'($signed(a)); y = longint'($signed(b));
          end else begin
            x = longint'({32'd0, a}); y = longint'({32'd0, b});
          end
          q = x / y; r = x % y;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
      end
`endif
      3'b100: exp_hi = a;
      3'b101: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one request, scramble the inputs after acceptance, count busy cycles.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 3'b000; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    rst = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
  endtask

  task automatic test_multu_corner;
    int cyc;
    do_op(3'b001, 32'hFFFF_FFFF, 32'h2, cyc);
    checks++; if (cyc != 32) begin errors++; $display("FAIL multu_busy_len: got %0d expected 32", cyc); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_mult_neg;
    int cyc;
    do_op(3'b000, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++; if (cyc != 32) begin errors++; $display("FAIL mult_busy_len: got %0d expected 32", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    exp_hi = hi; exp_lo = lo;
  endtask

  task automatic test_mthi_busy_ignore;
    int cyc;
    do_op(3'b100, 32'h1234, 32'h0, cyc);
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, exp_lo); end
    checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy: got %0d expected 0", cyc); end
    @(negedge clk);
    start = 1'b1; op = 3'b000; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1; op = 3'b101; A = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
      end
      if (cyc == 10) begin
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL hold_hi_midop: got %h expected 00001234", hi); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (cyc != 32) begin errors++; $display("FAIL ignore_busy_len: got %0d expected 32", cyc); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd30) begin errors++; $display("FAIL ignore_lo: got %h expected 0000001e", lo); end
    exp_hi = 32'h0; exp_lo = 32'd30;
  endtask

  task automatic test_rst_abort;
    @(negedge clk);
    start = 1'b1; op = 3'b001; A = 32'hFFFF_0000; B = 32'h0001_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", hi, lo); end
    repeat (40) @(negedge clk);
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_late_write: got %h_%h busy %b expected 0_0 busy 0", hi, lo, busy);
    end
    exp_hi = 32'h0; exp_lo = 32'h0;
  endtask

  task automatic test_div;
    int cyc;
`ifdef MDU_DIV_EN
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != 32) begin errors++; $display("FAIL div_busy_len: got %0d expected 32", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: got hi %h lo %h expected ffffffff fffffffd", hi, lo);
    end
    do_op(3'b011, 32'd7, 32'd0, cyc);
    checks++; if (cyc != 32 || lo !== 32'hFFFF_FFFF || hi !== 32'h7) begin
      errors++; $display("FAIL divu_zero: got cyc %0d hi %h lo %h expected 32 00000007 ffffffff", cyc, hi, lo);
    end
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow: got hi %h lo %h expected 0 80000000", hi, lo);
    end
    exp_hi = hi; exp_lo = lo;
`else
    exp_hi = hi; exp_lo = lo;
    do_op(3'b010, 32'd9, 32'd3, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL nodiv_busy: got %0d expected 0", cyc); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin
      errors++; $display("FAIL nodiv_hilo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo);
    end
`endif
  endtask

  task automatic test_noop;
    int cyc;
    for (int k = 6; k < 8; k++) begin
      do_op(3'(k), $urandom, $urandom, cyc);
      checks++; if (cyc != 0 || hi !== exp_hi || lo !== exp_lo) begin
        errors++; $display("FAIL noop_%0d: got cyc %0d %h_%h expected 0 %h_%h", k, cyc, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; op = 3'b101; A = 32'h0000_0ABC;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h0ABC || hi !== 32'h0) begin
      errors++; $display("FAIL start_after_rst: got %h_%h expected 00000000_00000abc", hi, lo);
    end
    exp_hi = 32'h0; exp_lo = 32'h0ABC;
    for (int k = 0; k < 2; k++) begin
      A = $urandom; B = $urandom;
      model(3'b001, A, B);
      do_op(3'b001, A, B, cyc);
      checks++; if (cyc != 32 || hi !== exp_hi || lo !== exp_lo) begin
        errors++; $display("FAIL b2b_%0d: got cyc %0d %h_%h expected 32 %h_%h", k, cyc, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_random;
    int          cyc;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 30; k++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom);
      model(o, a, b);
      do_op(o, a, b, cyc);
      checks++; if (cyc != exp_cyc || hi !== exp_hi || lo !== exp_lo) begin
        errors++; $display("FAIL random_op%0d a=%h b=%h: got cyc %0d %h_%h expected %0d %h_%h",
                           o, a, b, cyc, hi, lo, exp_cyc, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_multu_corner;
    test_mult_neg;
    test_mthi_busy_ignore;
    test_rst_abort;
    test_multu_corner;
    test_div;
    test_noop;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
